// File: rtl/data_memory_ctrl.sv
// Byte/half/word data memory for the MEM stage: loads return one cycle after the request edge, stores commit on it.
// busy is high through reset and the post-reset clear; every request is dropped while busy and nothing pushes back otherwise.
module data_memory_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rEn,
  input  logic              mem_wEn,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              misaligned,
  output logic              busy
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   clear_ptr_q, clear_ptr_d;
  logic [31:0]        read_data_q, read_data_d;
  logic               read_valid_q, read_valid_d;
  logic               misaligned_q, misaligned_d;
  logic [31:0]        mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]   idx;
  logic [1:0]         off;
  logic [31:0]        rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic               half_bad, word_bad;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_idx;
  logic [3:0]         mem_be;
  logic [31:0]        mem_wdat;

  // Upper address bits only alias the array.
  if (ADDR_W > IDX_W + 2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[ADDR_W-1:IDX_W+2];
  end

  assign idx      = address[IDX_W+1:2];
  assign off      = address[1:0];
  assign rd_word  = mem_q[idx];
  assign rd_byte  = 8'(rd_word >> {off, 3'b000});
  assign rd_half  = off[1] ? rd_word[31:16] : rd_word[15:0];
  assign half_bad = off[0];
  assign word_bad = (off != 2'b00);

  always_comb begin
    state_d      = state_q;
    clear_ptr_d  = clear_ptr_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    misaligned_d = 1'b0;
    mem_we       = 1'b0;
    mem_idx      = idx;
    mem_be       = 4'b0000;
    mem_wdat     = 32'h0;
    case (state_q)
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_idx  = clear_ptr_q;
        mem_be   = 4'b1111;
        if (clear_ptr_q == IDX_W'(DEPTH_WORDS - 1)) begin
          state_d     = S_IDLE;
          clear_ptr_d = '0;
        end else begin
          clear_ptr_d = clear_ptr_q + 1'b1;
        end
      end
      default: begin
        // A store wins over a simultaneous load; the load is simply dropped.
        if (mem_wEn) begin
          case (funct3)
            3'b000: begin
              mem_we   = 1'b1;
              mem_be   = 4'b0001 << off;
              mem_wdat = {4{write_data[7:0]}};
            end
            3'b001: begin
              if (half_bad) misaligned_d = 1'b1;
              else begin
                mem_we   = 1'b1;
                mem_be   = off[1] ? 4'b1100 : 4'b0011;
                mem_wdat = {2{write_data[15:0]}};
              end
            end
            3'b010: begin
              if (word_bad) misaligned_d = 1'b1;
              else begin
                mem_we   = 1'b1;
                mem_be   = 4'b1111;
                mem_wdat = write_data;
              end
            end
            default: ;
          endcase
        end else if (mem_rEn) begin
          case (funct3)
            3'b000: begin read_valid_d = 1'b1; read_data_d = {{24{rd_byte[7]}}, rd_byte}; end
            3'b100: begin read_valid_d = 1'b1; read_data_d = {24'h0, rd_byte}; end
            3'b001, 3'b101: begin
              if (half_bad) misaligned_d = 1'b1;
              else begin
                read_valid_d = 1'b1;
                read_data_d  = {{16{rd_half[15] & ~funct3[2]}}, rd_half};
              end
            end
            3'b010: begin
              if (word_bad) misaligned_d = 1'b1;
              else begin
                read_valid_d = 1'b1;
                read_data_d  = rd_word;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_CLEAR;
      clear_ptr_q  <= '0;
      read_data_q  <= 32'h0;
      read_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_ptr_q  <= clear_ptr_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_q[mem_idx][b*8 +: 8] <= mem_wdat[b*8 +: 8];
      end
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign misaligned = misaligned_q;
  assign busy       = (state_q == S_CLEAR);
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl with a 16-word array: load results are queued when issued and matched on read_valid.
module tb_data_memory_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rEn = 1'b0;
  logic        mem_wEn = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [15:0] address = 16'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        read_valid;
  logic        misaligned;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb [$];

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  data_memory_ctrl #(.ADDR_W(16), .DEPTH_WORDS(16)) dut (
    .clk(clk), .rst(rst), .mem_rEn(mem_rEn), .mem_wEn(mem_wEn), .funct3(funct3),
    .address(address), .write_data(write_data), .read_data(read_data),
    .read_valid(read_valid), .misaligned(misaligned), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every read_valid pulse consumes the oldest expected load result.
  always @(negedge clk) begin
    if (read_valid === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_read_valid: read_data=%08h with no load pending", read_data);
      end else begin
        logic [31:0] exp;
        exp = sb.pop_front();
        if (read_data !== exp) begin
          fails++;
          $display("FAIL load_data: got %08h expected %08h", read_data, exp);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [2:0] f,
                       input logic [15:0] a, input logic [31:0] d);
    mem_rEn = r; mem_wEn = w; funct3 = f; address = a; write_data = d;
    @(posedge clk); #1;
    mem_rEn = 1'b0; mem_wEn = 1'b0;
  endtask

  task automatic load(input logic [2:0] f, input logic [15:0] a, input logic [31:0] exp);
    sb.push_back(exp);
    drive(1'b1, 1'b0, f, a, 32'h0);
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (n < 64) begin
      @(posedge clk); #1;
      n++;
      mem_wEn = (n == 15);
      funct3 = F_W; address = 16'h003C; write_data = 32'hDEADBEEF;
      if (busy !== 1'b1) break;
    end
    mem_wEn = 1'b0; mem_rEn = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1 || read_valid !== 1'b0 || misaligned !== 1'b0 || read_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: busy=%b rv=%b mis=%b rd=%08h expected 1 0 0 00000000",
               busy, read_valid, misaligned, read_data);
    end
    // Requests from the very first clear cycle onward must be ignored.
    rst = 1'b1; mem_rEn = 1'b1; mem_wEn = 1'b1; funct3 = F_W; address = 16'h003C;
    write_data = 32'hDEADBEEF;
    wait_clear(n);
    tests++;
    if (n != 16) begin
      fails++;
      $display("FAIL busy_length: busy cycles %0d expected 16", n);
    end
    load(F_W, 16'h003C, 32'h00000000);
    tests++;
    if (read_valid !== 1'b1) begin
      fails++;
      $display("FAIL clear_load_valid: read_valid=%b expected 1", read_valid);
    end
  endtask

  task automatic test_word_round_trip;
    drive(1'b0, 1'b1, F_W, 16'h006F, 32'h11100011);
    tests++;
    if (misaligned !== 1'b1 || read_valid !== 1'b0) begin
      fails++;
      $display("FAIL sw_misaligned: mis=%b rv=%b expected 1 0", misaligned, read_valid);
    end
    load(F_W, 16'h006C, 32'h00000000);
    tests++;
    if (misaligned !== 1'b0) begin
      fails++;
      $display("FAIL misaligned_pulse_end: mis=%b expected 0", misaligned);
    end
    drive(1'b0, 1'b1, F_W, 16'h006C, 32'h11100011);
    load(F_W, 16'h006C, 32'h11100011);
    tests++;
    if (read_valid !== 1'b1) begin
      fails++;
      $display("FAIL raw_valid: read_valid=%b expected 1", read_valid);
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b0, 1'b1, F_W, 16'h0010, 32'h00000000);
    drive(1'b0, 1'b1, F_B, 16'h0011, 32'h00000080);
    drive(1'b0, 1'b1, F_H, 16'h0012, 32'h0000BEEF);
    load(F_W,  16'h0010, 32'hBEEF8000);
    load(F_B,  16'h0011, 32'hFFFFFF80);
    load(F_BU, 16'h0011, 32'h00000080);
    load(F_H,  16'h0012, 32'hFFFFBEEF);
    load(F_HU, 16'h0012, 32'h0000BEEF);
    tests++;
    if (read_valid !== 1'b1 || sb.size() != 1) begin
      fails++;
      $display("FAIL back_to_back: rv=%b pending=%0d expected 1 1", read_valid, sb.size());
    end
    load(F_BU, 16'h0013, 32'h000000BE);
  endtask

  task automatic test_misaligned;
    logic [2:0]  fs [4] = '{F_H, F_W, F_HU, 3'b011};
    logic [15:0] as [4] = '{16'h0013, 16'h0012, 16'h0011, 16'h0010};
    logic        ms [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, fs[i], as[i], 32'h0);
      tests++;
      if (misaligned !== ms[i] || read_valid !== 1'b0 || read_data !== 32'h000000BE) begin
        fails++;
        $display("FAIL load_reject_%0d: mis=%b rv=%b rd=%08h expected %b 0 000000be",
                 i, misaligned, read_valid, read_data, ms[i]);
      end
    end
    drive(1'b0, 1'b1, F_H, 16'h0011, 32'h0000AAAA);
    tests++;
    if (misaligned !== 1'b1) begin
      fails++;
      $display("FAIL sh_misaligned: mis=%b expected 1", misaligned);
    end
    drive(1'b0, 1'b1, 3'b011, 16'h0010, 32'h55555555);
    tests++;
    if (misaligned !== 1'b0) begin
      fails++;
      $display("FAIL store_bad_funct3: mis=%b expected 0", misaligned);
    end
    load(F_W, 16'h0010, 32'hBEEF8000);
  endtask

  task automatic test_wrap_collision;
    drive(1'b0, 1'b1, F_W, 16'h0040, 32'hCAFEF00D);
    load(F_W, 16'h0000, 32'hCAFEF00D);
    drive(1'b1, 1'b1, F_W, 16'h0004, 32'h12345678);
    tests++;
    if (read_valid !== 1'b0 || misaligned !== 1'b0) begin
      fails++;
      $display("FAIL collision: rv=%b mis=%b expected 0 0", read_valid, misaligned);
    end
    load(F_W, 16'h0004, 32'h12345678);
    drive(1'b1, 1'b1, F_W, 16'h0006, 32'hFFFFFFFF);
    tests++;
    if (read_valid !== 1'b0 || misaligned !== 1'b1) begin
      fails++;
      $display("FAIL collision_misaligned: rv=%b mis=%b expected 0 1", read_valid, misaligned);
    end
    load(F_W, 16'h0004, 32'h12345678);
  endtask

  task automatic test_reset_mid;
    int n;
    rst = 1'b0;
    drive(1'b1, 1'b0, F_W, 16'h0010, 32'h0);
    tests++;
    if (read_valid !== 1'b0 || read_data !== 32'h0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: rv=%b rd=%08h busy=%b expected 0 00000000 1",
               read_valid, read_data, busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    wait_clear(n);
    tests++;
    if (n != 16) begin
      fails++;
      $display("FAIL reclear_length: busy cycles %0d expected 16", n);
    end
    load(F_W, 16'h0010, 32'h00000000);
    load(F_W, 16'h0000, 32'h00000000);
    load(F_W, 16'h003C, 32'h00000000);
  endtask

  initial begin
    test_reset;
    test_word_round_trip;
    test_back_to_back;
    test_misaligned;
    test_wrap_collision;
    test_reset_mid;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing_read_valid: %0d expected loads never returned", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
